// File: rtl/uart_frame_packer_if.sv
// rtl/uart_frame_packer_if.sv - word-in / byte-out bus between dB converter, packer and UART FIFO
interface uart_frame_packer_if #(
    parameter int DW = 16
);
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic          fifo_full_i;
    logic [7:0]    data_o;
    logic          wr_en_o;
    logic          busy_o;
    logic [7:0]    seq_o;
    logic [7:0]    drop_count_o;

    // Packer side
    modport slave (
        input  data_i, valid_i, fifo_full_i,
        output ready_o, data_o, wr_en_o, busy_o, seq_o, drop_count_o
    );

    // Source / FIFO side
    modport master (
        output data_i, valid_i, fifo_full_i,
        input  ready_o, data_o, wr_en_o, busy_o, seq_o, drop_count_o
    );
endinterface

// File: rtl/uart_frame_packer.sv
// rtl/uart_frame_packer.sv - serialises dB power words into SYNC/SEQ/DATA/CSUM byte frames
module uart_frame_packer #(
    parameter int         DW        = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    localparam int        NBYTES    = DW / 8
) (
    input  logic               clk,
    input  logic               rst,
    uart_frame_packer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_DATA,
        S_CSUM
    } state_t;

    // Byte index never exceeds 3 (DW <= 32)
    localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

    state_t        r_state;
    logic [DW-1:0] r_word;
    logic [1:0]    r_idx;
    logic [7:0]    r_csum;
    logic [7:0]    r_seq;
    logic [7:0]    r_drop;

    logic [DW-1:0] w_shift;
    logic [7:0]    w_byte;
    logic          w_wr;

    // Current data byte is always the top byte after shifting out the ones already sent
    assign w_shift = r_word << {r_idx, 3'b000};

    // Byte to present, selected purely from registered state so valid_i never reaches data_o
    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            S_SYNC:  w_byte = SYNC_BYTE;
            S_SEQ:   w_byte = r_seq;
            S_DATA:  w_byte = w_shift[DW-1 -: 8];
            S_CSUM:  w_byte = r_csum;
            default: w_byte = 8'h00;
        endcase
    end

    assign w_wr             = (r_state != S_IDLE) && !bus.fifo_full_i;
    assign bus.wr_en_o      = w_wr;
    assign bus.data_o       = w_byte;
    assign bus.ready_o      = (r_state == S_IDLE);
    assign bus.busy_o       = (r_state != S_IDLE);
    assign bus.seq_o        = r_seq;
    assign bus.drop_count_o = r_drop;

    // Frame FSM: capture in IDLE, advance one byte per accepted FIFO write, count drops while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_idx   <= 2'd0;
            r_csum  <= 8'h00;
            r_seq   <= 8'h00;
            r_drop  <= 8'h00;
        end else begin
            if (bus.valid_i && (r_state != S_IDLE) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'h01;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        r_word  <= bus.data_i;
                        r_csum  <= 8'h00;
                        r_idx   <= 2'd0;
                        r_state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (w_wr) begin
                        r_state <= S_SEQ;
                    end
                end
                S_SEQ: begin
                    if (w_wr) begin
                        r_csum  <= r_csum + w_byte;
                        r_idx   <= 2'd0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_wr) begin
                        r_csum <= r_csum + w_byte;
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_wr) begin
                        r_seq   <= r_seq + 8'h01;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
